digit_frame_loader: RTL and testbench
=====================================

# digit_frame_loader

Host-side driver for the digit-detector top level. Accepts a 28×28 frame of signed pixels on a valid/ready stream and writes it into the detector's database port at addresses 0..783. It then pulses GO, waits for the STOP completion handshake and captures the 4-bit RESULT. It is the initiator/writer end of the detector's database-load and GO/STOP/RESULT interface.

## Interface
Parameters:
- SIZE_1, 12, pixel word width (signed)
- PIXELS, 784, pixels per frame (28×28)
- ADDR_W, 13, database address width
- GO_CYCLES, 2, GO high duration in clocks (≥1)
- TIMEOUT_W, 24, width of the completion-timeout counter; timeout = 2^TIMEOUT_W−1 cycles

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- s_valid  in  1  pixel beat valid
- s_ready  out  1  loader accepts a beat this cycle
- s_data  in  SIZE_1  signed pixel, raster order, row 0 first
- busy  out  1  high in any state other than IDLE
- we_database  out  1  database write enable
- dp_database  out  SIZE_1  database write data
- address_p_database  out  ADDR_W  database write address
- GO  out  1  start pulse to detector
- STOP  in  1  detector done flag (low while running, high when finished)
- RESULT  in  4  detector class output, valid while STOP=1
- digit  out  4  captured class; 4'hF after timeout
- digit_valid  out  1  one-cycle pulse when digit updates
- timeout_err  out  1  sticky; set on timeout, cleared on first accepted beat of next frame

## Operation
- States: IDLE, LOAD, GO_ON, WAIT_LOW, WAIT_DONE.
- IDLE: s_ready=1. The first accepted beat enters LOAD, clears pixel index idx and timeout_err, and writes that beat.
- LOAD: s_ready=1. Each accepted beat (s_valid&s_ready) registers one write: we_database=1, address_p_database=idx, dp_database=s_data. idx then increments. Cycles with s_valid=0 produce we_database=0, and address/data hold their values.
- The accepted beat with idx=PIXELS−1 is the last. s_ready drops the following cycle, and the state moves to GO_ON. Beats beyond PIXELS are never accepted in the same frame.
- GO_ON: GO=1 for exactly GO_CYCLES cycles, then WAIT_LOW. we_database=0 throughout.
- WAIT_LOW: wait for sampled STOP=0. This ignores a stale STOP=1 from the previous frame or power-up. When STOP=0 is seen, go to WAIT_DONE.
- WAIT_DONE: on the first sampled STOP=1, latch digit←RESULT, pulse digit_valid, and go to IDLE.
- Timeout: a counter clears on entry to WAIT_LOW and increments in WAIT_LOW/WAIT_DONE. At all-ones it sets timeout_err, forces digit=4'hF, pulses digit_valid, and returns to IDLE.
- s_ready=0 in GO_ON/WAIT_LOW/WAIT_DONE. Beats offered there are stalled, not dropped.
- RESULT is passed through without range checking; values 10..15 are latched as-is.

## Timing
- Reset values: s_ready=0 during reset, then 1 from the first cycle after release (IDLE); busy=0; we_database=0; dp_database=0; address_p_database=0; GO=0; digit=4'hF; digit_valid=0; timeout_err=0; state=IDLE; idx=0.
- Write latency: a beat accepted at edge N appears on the database port after edge N (registered), valid for one cycle.
- GO rises on the edge after the last write's we_database cycle. There is no overlap between we_database and GO.
- Minimum frame time with s_valid held high: 784 + GO_CYCLES + (detector run) + 1 cycles.
- digit_valid and the digit update occur on the edge after STOP is first sampled high in WAIT_DONE.
- Reset mid-frame: all outputs return immediately (asynchronously) to reset values, and GO drops even mid-pulse. The partially written database is left as-is, and the next frame restarts at address 0.
- STOP sampled directly (same clock domain), no synchronizer.

## Test plan
- Full frame, s_valid always 1, pixel = idx−392: 784 writes at addresses 0..783 with matching data. GO is high 2 cycles on the cycle after address 783. The detector model holds STOP=0 for 100 cycles then STOP=1 with RESULT=7 → digit=7, one digit_valid pulse, busy falls.
- Random s_valid gaps (50%): exactly 784 writes with no duplicate or skipped address, and s_ready=0 from the cycle after beat 783 until return to IDLE.
- Stale STOP: STOP held 1 through GO, falls 5 cycles later, rises with RESULT=3 → no early capture; digit=3.
- Timeout (TIMEOUT_W=6): STOP never returns to 1 → after 63 cycles in WAIT_*, timeout_err=1, digit=4'hF, digit_valid pulses. The next frame's first beat clears timeout_err.
- rst asserted at beat 400 and during GO_ON: GO, we_database and busy drop at once. After release, a new frame writes starting at address 0.
- Back-to-back frames: a second frame offered during WAIT_DONE stalls (s_ready=0), then loads starting the cycle after digit_valid.

Source files
------------

// File: rtl/digit_frame_loader_if.sv
// Signal bundle between the frame loader, the pixel source and the digit detector.
// The master modport is the loader side; the slave modport is the source/detector side.
interface digit_frame_loader_if #(
  parameter int SIZE_1 = 12,
  parameter int ADDR_W = 13
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [SIZE_1-1:0] s_data;
  logic                     busy;
  logic                     we_database;
  logic signed [SIZE_1-1:0] dp_database;
  logic [ADDR_W-1:0]        address_p_database;
  logic                     GO;
  logic                     STOP;
  logic [3:0]               RESULT;
  logic [3:0]               digit;
  logic                     digit_valid;
  logic                     timeout_err;

  modport master (
    input  s_valid, s_data, STOP, RESULT,
    output s_ready, busy, we_database, dp_database, address_p_database,
           GO, digit, digit_valid, timeout_err
  );

  modport slave (
    output s_valid, s_data, STOP, RESULT,
    input  s_ready, busy, we_database, dp_database, address_p_database,
           GO, digit, digit_valid, timeout_err
  );
endinterface

// File: rtl/digit_frame_loader.sv
// Loads one 28x28 signed pixel frame into the detector database, pulses GO,
// waits for the STOP handshake (with timeout) and captures the RESULT class.
module digit_frame_loader #(
  parameter int SIZE_1    = 12,
  parameter int PIXELS    = 784,
  parameter int ADDR_W    = 13,
  parameter int GO_CYCLES = 2,
  parameter int TIMEOUT_W = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  digit_frame_loader_if.master        host_io
);

  localparam int GW = $clog2(GO_CYCLES + 1);
  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(PIXELS - 1);
  localparam logic [GW-1:0]        GO_LAST  = GW'(GO_CYCLES);
  // Fires when the counter would reach all-ones: 2^TIMEOUT_W-1 wait cycles in total.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_GO_ON     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [GW-1:0]            go_cnt_q, go_cnt_d;
  logic [TIMEOUT_W-1:0]     tmo_q, tmo_d;
  logic                     s_ready_q, s_ready_d;
  logic                     busy_q, busy_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic signed [SIZE_1-1:0] dp_q, dp_d;
  logic                     go_q, go_d;
  logic [3:0]               digit_q, digit_d;
  logic                     digit_valid_q, digit_valid_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     accept_s;
  logic                     last_s;
  logic [ADDR_W-1:0]        cur_idx_s;

  assign accept_s  = host_io.s_valid & s_ready_q;
  assign cur_idx_s = (state_q == S_IDLE) ? {ADDR_W{1'b0}} : idx_q;
  assign last_s    = (cur_idx_s == LAST_IDX);

  // Next-state and next-output logic for the load / start / wait sequence.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    go_cnt_d      = go_cnt_q;
    tmo_d         = tmo_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    dp_d          = dp_q;
    go_d          = 1'b0;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept_s) begin
          we_d          = 1'b1;
          addr_d        = cur_idx_s;
          dp_d          = host_io.s_data;
          idx_d         = cur_idx_s + ADDR_W'(1);
          timeout_err_d = 1'b0;
          if (last_s) begin
            state_d  = S_GO_ON;
            go_cnt_d = {GW{1'b0}};
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end

      // First GO_ON cycle carries the last write; GO follows it without overlap.
      S_GO_ON: begin
        if (go_cnt_q == GO_LAST) begin
          state_d = S_WAIT_LOW;
          tmo_d   = {TIMEOUT_W{1'b0}};
        end else begin
          go_d     = 1'b1;
          go_cnt_d = go_cnt_q + GW'(1);
        end
      end

      S_WAIT_LOW, S_WAIT_DONE: begin
        if ((state_q == S_WAIT_DONE) && host_io.STOP) begin
          digit_d       = host_io.RESULT;
          digit_valid_d = 1'b1;
          state_d       = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          digit_d       = 4'hF;
          digit_valid_d = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
          if ((state_q == S_WAIT_LOW) && !host_io.STOP) begin
            state_d = S_WAIT_DONE;
          end else begin
            state_d = state_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= {ADDR_W{1'b0}};
      go_cnt_q      <= {GW{1'b0}};
      tmo_q         <= {TIMEOUT_W{1'b0}};
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= {ADDR_W{1'b0}};
      dp_q          <= {SIZE_1{1'b0}};
      go_q          <= 1'b0;
      digit_q       <= 4'hF;
      digit_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      go_cnt_q      <= go_cnt_d;
      tmo_q         <= tmo_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      dp_q          <= dp_d;
      go_q          <= go_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign host_io.s_ready            = s_ready_q;
  assign host_io.busy               = busy_q;
  assign host_io.we_database        = we_q;
  assign host_io.dp_database        = dp_q;
  assign host_io.address_p_database = addr_q;
  assign host_io.GO                 = go_q;
  assign host_io.digit              = digit_q;
  assign host_io.digit_valid        = digit_valid_q;
  assign host_io.timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_digit_frame_loader.sv
// Directed bench for digit_frame_loader: main instance with the default timeout,
// second instance with TIMEOUT_W=6 for the completion-timeout path.
module tb_digit_frame_loader;
  localparam int SZ   = 12;
  localparam int NPIX = 784;
  localparam int AW   = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_frame_loader_if #(.SIZE_1(SZ), .ADDR_W(AW)) if0 ();
  digit_frame_loader_if #(.SIZE_1(SZ), .ADDR_W(AW)) ift ();

  digit_frame_loader #(.SIZE_1(SZ), .PIXELS(NPIX), .ADDR_W(AW), .GO_CYCLES(2), .TIMEOUT_W(24))
    dut (.clk(clk), .rst(rst), .host_io(if0.master));
  digit_frame_loader #(.SIZE_1(SZ), .PIXELS(NPIX), .ADDR_W(AW), .GO_CYCLES(2), .TIMEOUT_W(6))
    dut_t (.clk(clk), .rst(rst), .host_io(ift.master));

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [SZ-1:0] pix [NPIX];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write monitor: address sequence, data, GO placement/length, s_ready tail.
  int   wr_cnt = 0;
  int   exp_addr = 0;
  int   go_len = 0;
  logic prev_last = 1'b0;
  logic tail = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_addr  = 0;
      go_len    = 0;
      prev_last = 1'b0;
      tail      = 1'b0;
    end else begin
      if (prev_last) check_eq("go_after_last", {31'd0, if0.GO}, 32'd1);
      prev_last = 1'b0;
      if (if0.we_database) begin
        check_eq("wr_addr", {19'd0, if0.address_p_database}, exp_addr);
        check_eq("wr_data", if0.dp_database, pix[exp_addr]);
        check_eq("we_go_excl", {31'd0, if0.GO}, 32'd0);
        wr_cnt = wr_cnt + 1;
        if (exp_addr == NPIX - 1) begin
          check_eq("ready_drop", {31'd0, if0.s_ready}, 32'd0);
          prev_last = 1'b1;
          tail      = 1'b1;
          exp_addr  = 0;
        end else begin
          exp_addr = exp_addr + 1;
        end
      end else if (tail) begin
        if (if0.busy) check_eq("ready_tail", {31'd0, if0.s_ready}, 32'd0);
        else tail = 1'b0;
      end
      if (if0.GO) go_len = go_len + 1;
      else if (go_len != 0) begin
        check_eq("go_len", go_len, 32'd2);
        go_len = 0;
      end
    end
  end

  // Streams pix[] into if0; gap>0 gives that percentage of idle cycles.
  task automatic send_frame(input int gap, input int stop_at);
    int   k = 0;
    int   budget = 0;
    logic acc;
    while (k < NPIX && budget < 6000) begin
      if (k == stop_at) return;
      if0.s_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      if0.s_data  = pix[k];
      acc = if0.s_valid && if0.s_ready;
      step(1);
      if (acc) k = k + 1;
      budget = budget + 1;
    end
    if0.s_valid = 1'b0;
    check_eq("send_done", k, NPIX);
  endtask

  // Detector model: optional stale STOP=1 through GO plus 5 cycles, then run.
  task automatic detector(input bit stale, input int run, input logic [3:0] res);
    int n = 0;
    while (!if0.GO && n < 8000) begin
      step(1);
      n = n + 1;
    end
    check_eq("go_seen", {31'd0, if0.GO}, 32'd1);
    if (stale) begin
      if0.STOP   = 1'b1;
      if0.RESULT = 4'd9;
      while (if0.GO) step(1);
      step(5);
    end
    if0.STOP = 1'b0;
    step(run);
    if0.RESULT = res;
    if0.STOP   = 1'b1;
  endtask

  task automatic wait_result(input logic [3:0] exp);
    int n = 0;
    @(negedge clk);
    while (!if0.digit_valid && n < 20000) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq("dv_seen", {31'd0, if0.digit_valid}, 32'd1);
    check_eq("digit", {28'd0, if0.digit}, {28'd0, exp});
    check_eq("terr_clear", {31'd0, if0.timeout_err}, 32'd0);
    @(negedge clk);
    check_eq("dv_pulse", {31'd0, if0.digit_valid}, 32'd0);
    check_eq("busy_fall", {31'd0, if0.busy}, 32'd0);
    check_eq("ready_idle", {31'd0, if0.s_ready}, 32'd1);
    step(1);
  endtask

  initial begin
    int wr0;
    int n;
    if0.s_valid = 1'b0; if0.s_data = '0; if0.STOP = 1'b0; if0.RESULT = 4'd0;
    ift.s_valid = 1'b0; ift.s_data = '0; ift.STOP = 1'b0; ift.RESULT = 4'd0;
    for (int i = 0; i < NPIX; i++) pix[i] = SZ'(i - 392);

    // Reset values
    step(2);
    check_eq("rst_ready", {31'd0, if0.s_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, if0.busy}, 32'd0);
    check_eq("rst_we", {31'd0, if0.we_database}, 32'd0);
    check_eq("rst_dp", if0.dp_database, 32'd0);
    check_eq("rst_addr", {19'd0, if0.address_p_database}, 32'd0);
    check_eq("rst_go", {31'd0, if0.GO}, 32'd0);
    check_eq("rst_digit", {28'd0, if0.digit}, 32'hF);
    check_eq("rst_dv", {31'd0, if0.digit_valid}, 32'd0);
    check_eq("rst_terr", {31'd0, if0.timeout_err}, 32'd0);
    rst = 1'b0;
    step(1);
    check_eq("ready_after_rst", {31'd0, if0.s_ready}, 32'd1);

    // Full frame, s_valid held high, RESULT=7 after 100 cycles
    wr0 = wr_cnt;
    fork
      send_frame(0, -1);
      detector(1'b0, 100, 4'd7);
    join
    wait_result(4'd7);
    check_eq("wr_count_full", wr_cnt - wr0, NPIX);

    // 50% s_valid gaps
    for (int i = 0; i < NPIX; i++) pix[i] = SZ'(i * 5 - 1500);
    wr0 = wr_cnt;
    fork
      send_frame(50, -1);
      detector(1'b0, 40, 4'd2);
    join
    wait_result(4'd2);
    check_eq("wr_count_gaps", wr_cnt - wr0, NPIX);

    // Stale STOP=1 with RESULT=9 must not be captured
    for (int i = 0; i < NPIX; i++) pix[i] = SZ'(2047 - i * 3);
    fork
      send_frame(0, -1);
      detector(1'b1, 20, 4'd3);
    join
    wait_result(4'd3);

    // Reset at beat 400
    send_frame(0, 400);
    rst = 1'b1;
    #1;
    check_eq("rst400_we", {31'd0, if0.we_database}, 32'd0);
    check_eq("rst400_busy", {31'd0, if0.busy}, 32'd0);
    check_eq("rst400_ready", {31'd0, if0.s_ready}, 32'd0);
    check_eq("rst400_addr", {19'd0, if0.address_p_database}, 32'd0);
    if0.s_valid = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset while GO is high
    send_frame(0, -1);
    n = 0;
    while (!if0.GO && n < 20) begin
      step(1);
      n = n + 1;
    end
    check_eq("go_before_rst", {31'd0, if0.GO}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rstgo_go", {31'd0, if0.GO}, 32'd0);
    check_eq("rstgo_busy", {31'd0, if0.busy}, 32'd0);
    check_eq("rstgo_we", {31'd0, if0.we_database}, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Fresh frame after reset, out-of-range class passed through
    wr0 = wr_cnt;
    fork
      send_frame(0, -1);
      detector(1'b0, 10, 4'd12);
    join
    wait_result(4'd12);
    check_eq("wr_count_after_rst", wr_cnt - wr0, NPIX);

    // Back-to-back frames: second stalls until the cycle after digit_valid
    wr0 = wr_cnt;
    fork
      begin
        send_frame(0, -1);
        send_frame(0, -1);
      end
      begin
        detector(1'b0, 30, 4'd5);
        detector(1'b0, 10, 4'd6);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!if0.digit_valid && n < 20000) begin
          @(negedge clk);
          n = n + 1;
        end
        check_eq("b2b_dv", {31'd0, if0.digit_valid}, 32'd1);
        check_eq("b2b_digit", {28'd0, if0.digit}, 32'd5);
        check_eq("b2b_ready", {31'd0, if0.s_ready}, 32'd1);
        @(negedge clk);
        check_eq("b2b_first_we", {31'd0, if0.we_database}, 32'd1);
        check_eq("b2b_first_addr", {19'd0, if0.address_p_database}, 32'd0);
      end
    join
    wait_result(4'd6);
    check_eq("wr_count_b2b", wr_cnt - wr0, 2 * NPIX);

    // Timeout on the TIMEOUT_W=6 instance
    ift.s_valid = 1'b1;
    ift.s_data  = 12'sd5;
    n = 0;
    while (!ift.GO && n < 3000) begin
      step(1);
      n = n + 1;
    end
    check_eq("t_go_seen", {31'd0, ift.GO}, 32'd1);
    ift.s_valid = 1'b0;
    n = 0;
    while (ift.GO && n < 10) begin
      @(negedge clk);
      n = n + 1;
    end
    n = 0;
    while (!ift.digit_valid && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq("t_wait_cycles", n, 32'd63);
    check_eq("t_terr", {31'd0, ift.timeout_err}, 32'd1);
    check_eq("t_digit", {28'd0, ift.digit}, 32'hF);
    @(negedge clk);
    check_eq("t_dv_pulse", {31'd0, ift.digit_valid}, 32'd0);
    check_eq("t_terr_sticky", {31'd0, ift.timeout_err}, 32'd1);
    check_eq("t_ready", {31'd0, ift.s_ready}, 32'd1);
    ift.s_valid = 1'b1;
    step(1);
    ift.s_valid = 1'b0;
    check_eq("t_terr_cleared", {31'd0, ift.timeout_err}, 32'd0);
    check_eq("t_next_we", {31'd0, ift.we_database}, 32'd1);
    check_eq("t_next_addr", {19'd0, ift.address_p_database}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
